// File: rtl/aes_inv_key_sched.sv
// -----------------------------------------------------------------------------
// aes_inv_key_sched
//
// Decryption-side AES-128 key scheduler. A cipher key is loaded on start,
// expanded forward for ten cycles to reach round key 10, and then the round
// keys are handed out in reverse order (10 down to 0), one per rk_valid /
// rk_ready handshake. Only one 128-bit key is stored. Each earlier round key
// is recomputed in place from the current one by the inverse expansion step.
//
// Ports:
//   clk        in   1    rising-edge clock
//   rst_n      in   1    asynchronous active-low reset
//   start      in   1    load request, sampled only while idle
//   key_in     in   128  cipher key (round key 0), word 0 = [127:96]
//   rk_ready   in   1    consumer accepts the presented round key
//   rk_valid   out  1    round_key / rk_round are valid
//   round_key  out  128  current round key, word 0 = [127:96]
//   rk_round   out  4    round index of round_key (10..0)
//   busy       out  1    high while expanding or serving
//   done       out  1    one-cycle pulse after round key 0 is accepted
// -----------------------------------------------------------------------------
module aes_inv_key_sched (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [127:0] round_key,
    output logic [3:0]   rk_round,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_SERVE  = 2'd2
    } state_t;

    // Forward AES S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Single-byte S-box lookup. Entry b sits at bit offset (255-b)*8 = {~b,3'b000}.
    function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
        logic [10:0] idx;
        idx = {~b, 3'b000};
        return SBOX_TABLE[idx +: 8];
    endfunction

    // SubWord: four parallel byte lookups.
    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox_lookup(x[31:24]), sbox_lookup(x[23:16]),
                sbox_lookup(x[15:8]),  sbox_lookup(x[7:0])};
    endfunction

    // RotWord({a,b,c,d}) = {b,c,d,a}.
    function automatic logic [31:0] rot_word(input logic [31:0] x);
        return {x[23:0], x[31:24]};
    endfunction

    // Round constant byte for rounds 1..10; zero elsewhere.
    function automatic logic [7:0] rcon_byte(input logic [3:0] i);
        logic [7:0] rc;
        case (i)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    state_t       r_state;
    state_t       w_state_nxt;
    logic [127:0] r_key;
    logic [127:0] w_key_nxt;
    logic [3:0]   r_rnd;
    logic [3:0]   w_rnd_nxt;
    logic         r_done;
    logic         w_done_nxt;
    logic         r_valid;
    logic         r_busy;

    logic [31:0]  w_w0;
    logic [31:0]  w_w1;
    logic [31:0]  w_w2;
    logic [31:0]  w_w3;
    logic [31:0]  w_p3;
    logic [31:0]  w_sub_in;
    logic [31:0]  w_t;
    logic [31:0]  w_n0;
    logic [31:0]  w_n1;
    logic [31:0]  w_n2;
    logic [31:0]  w_n3;
    logic [3:0]   w_rcon_idx;
    logic [3:0]   w_rnd_inc;
    logic [3:0]   w_rnd_dec;
    logic [127:0] w_fwd;
    logic [127:0] w_inv;

    // Key datapath: one shared SubWord feeds both the forward and inverse step.
    always_comb begin
        w_w0      = r_key[127:96];
        w_w1      = r_key[95:64];
        w_w2      = r_key[63:32];
        w_w3      = r_key[31:0];
        // Previous round's w3 is recovered first; it is the SubWord source
        // when stepping backwards.
        w_p3      = w_w3 ^ w_w2;
        w_rnd_inc = r_rnd + 4'd1;
        w_rnd_dec = r_rnd - 4'd1;
        if (r_state == S_SERVE) begin
            w_sub_in   = w_p3;
            w_rcon_idx = r_rnd;
        end else begin
            w_sub_in   = w_w3;
            w_rcon_idx = w_rnd_inc;
        end
        w_t   = sub_word(rot_word(w_sub_in)) ^ {rcon_byte(w_rcon_idx), 24'h000000};
        w_n0  = w_w0 ^ w_t;
        w_n1  = w_w1 ^ w_n0;
        w_n2  = w_w2 ^ w_n1;
        w_n3  = w_w3 ^ w_n2;
        w_fwd = {w_n0, w_n1, w_n2, w_n3};
        w_inv = {w_w0 ^ w_t, w_w1 ^ w_w0, w_w2 ^ w_w1, w_p3};
    end

    // Next-state logic for the IDLE / EXPAND / SERVE sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_key_nxt   = r_key;
        w_rnd_nxt   = r_rnd;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_key_nxt   = key_in;
                    w_rnd_nxt   = 4'd0;
                    w_state_nxt = S_EXPAND;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_EXPAND: begin
                w_key_nxt = w_fwd;
                w_rnd_nxt = w_rnd_inc;
                if (w_rnd_inc == 4'd10) begin
                    w_state_nxt = S_SERVE;
                end else begin
                    w_state_nxt = S_EXPAND;
                end
            end
            S_SERVE: begin
                if (rk_ready) begin
                    if (r_rnd != 4'd0) begin
                        w_key_nxt = w_inv;
                        w_rnd_nxt = w_rnd_dec;
                    end else begin
                        // Round 0 accepted: key and index are left as they are.
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_state_nxt = S_SERVE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_key_nxt   = 128'h0;
                w_rnd_nxt   = 4'd0;
            end
        endcase
    end

    // State, key, round and status registers; status flags follow the next state
    // so rk_valid and busy come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_key   <= 128'h0;
            r_rnd   <= 4'd0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_key   <= w_key_nxt;
            r_rnd   <= w_rnd_nxt;
            r_done  <= w_done_nxt;
            r_valid <= (w_state_nxt == S_SERVE);
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    assign rk_valid  = r_valid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign round_key = r_key;
    assign rk_round  = r_rnd;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// -----------------------------------------------------------------------------
// tb_aes_inv_key_sched
//
// Self-checking bench for aes_inv_key_sched. Expected round keys come from
// FIPS-197 constants and from an independent forward-only key expansion model.
// -----------------------------------------------------------------------------
module tb_aes_inv_key_sched;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         rk_ready;
    logic         rk_valid;
    logic [127:0] round_key;
    logic [3:0]   rk_round;
    logic         busy;
    logic         done;

    int n_cmp;
    int n_fail;

    logic [127:0] exp_rk [0:10];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] FIPS_R9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] ONES_KEY = 128'hffffffffffffffffffffffffffffffff;
    localparam logic [127:0] ALT_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] BAD_KEY  = 128'h0123456789abcdeffedcba9876543210;

    localparam logic [2047:0] TB_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    aes_inv_key_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key_in    (key_in),
        .rk_ready  (rk_ready),
        .rk_valid  (rk_valid),
        .round_key (round_key),
        .rk_round  (rk_round),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] tb_sb(input logic [7:0] b);
        int idx;
        idx = 2047 - 8 * int'(b);
        return TB_SBOX[idx -: 8];
    endfunction

    // Forward expansion step from round i-1 to round i, Rcon by repeated xtime.
    function automatic logic [127:0] fwd_model(input logic [127:0] k, input int i);
        logic [31:0] w0, w1, w2, w3, t;
        logic [7:0]  rc;
        w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
        t  = {w3[23:0], w3[31:24]};
        t  = {tb_sb(t[31:24]), tb_sb(t[23:16]), tb_sb(t[15:8]), tb_sb(t[7:0])};
        rc = 8'h01;
        for (int j = 1; j < i; j++) rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        t[31:24] = t[31:24] ^ rc;
        w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    task automatic build_model(input logic [127:0] k);
        exp_rk[0] = k;
        for (int i = 1; i <= 10; i++) exp_rk[i] = fwd_model(exp_rk[i-1], i);
    endtask

    task automatic do_start(input logic [127:0] k);
        key_in = k;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (rk_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; key_in = 128'h0; rk_ready = 1'b0;
        #12;
        n_cmp++;
        if (rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || round_key !== 128'h0 || rk_round !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%b busy=%b done=%b round=%0d key=%h, expected all zero",
                     rk_valid, busy, done, rk_round, round_key);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (rk_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got valid=%b busy=%b, expected 0 0", rk_valid, busy);
        end
    endtask

    task automatic test_fips();
        int lat;
        int n_done;
        logic [127:0] expv;
        build_model(FIPS_KEY);
        rk_ready = 1'b1;
        do_start(FIPS_KEY);
        n_cmp++;
        if (busy !== 1'b1 || rk_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fips_expand_flags: got busy=%b valid=%b, expected 1 0", busy, rk_valid);
        end
        wait_valid(lat);
        n_cmp++;
        if (lat !== 10) begin
            n_fail++;
            $display("FAIL fips_latency: got %0d cycles, expected 10", lat);
        end
        n_done = 0;
        for (int r = 10; r >= 0; r--) begin
            expv = (r == 10) ? FIPS_R10 : (r == 9) ? FIPS_R9 : (r == 1) ? FIPS_R1 :
                   (r == 0) ? FIPS_KEY : exp_rk[r];
            n_done += int'(done);
            n_cmp++;
            if (rk_valid !== 1'b1 || rk_round !== 4'(r) || round_key !== expv) begin
                n_fail++;
                $display("FAIL fips_round: got valid=%b round=%0d key=%h, expected 1 %0d %h",
                         rk_valid, rk_round, round_key, r, expv);
            end
            @(posedge clk); #1;
        end
        n_done += int'(done);
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || rk_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fips_done_cycle: got done=%b busy=%b valid=%b, expected 1 0 0", done, busy, rk_valid);
        end
        rk_ready = 1'b0;
        @(posedge clk); #1;
        n_done += int'(done);
        n_cmp++;
        if (n_done !== 1) begin
            n_fail++;
            $display("FAIL fips_done_pulses: got %0d pulses, expected 1", n_done);
        end
    endtask

    task automatic test_random_ready();
        int lat;
        int r;
        int hs;
        int cyc;
        build_model(FIPS_KEY);
        rk_ready = 1'b0;
        do_start(FIPS_KEY);
        wait_valid(lat);
        n_cmp++;
        if (lat !== 10) begin
            n_fail++;
            $display("FAIL rr_latency: got %0d cycles, expected 10", lat);
        end
        r = 10; hs = 0; cyc = 0;
        while (r >= 0 && cyc < 400) begin
            rk_ready = 1'($urandom_range(0, 1));
            n_cmp++;
            if (rk_valid !== 1'b1 || rk_round !== 4'(r) || round_key !== exp_rk[r]) begin
                n_fail++;
                $display("FAIL rr_round: got valid=%b round=%0d key=%h, expected 1 %0d %h",
                         rk_valid, rk_round, round_key, r, exp_rk[r]);
            end
            @(posedge clk); #1;
            if (rk_ready) begin
                hs++;
                r--;
            end
            cyc++;
        end
        rk_ready = 1'b0;
        n_cmp++;
        if (hs !== 11 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_handshakes: got %0d handshakes done=%b, expected 11 1", hs, done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_ignored();
        int lat;
        build_model(FIPS_KEY);
        rk_ready = 1'b0;
        do_start(FIPS_KEY);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        do_start(BAD_KEY);
        wait_valid(lat);
        n_cmp++;
        if (lat !== 6) begin
            n_fail++;
            $display("FAIL ign_latency: got %0d cycles, expected 6", lat);
        end
        do_start(BAD_KEY);
        n_cmp++;
        if (rk_valid !== 1'b1 || rk_round !== 4'd10 || round_key !== exp_rk[10]) begin
            n_fail++;
            $display("FAIL ign_serve_start: got valid=%b round=%0d key=%h, expected 1 10 %h",
                     rk_valid, rk_round, round_key, exp_rk[10]);
        end
        rk_ready = 1'b1;
        for (int r = 10; r >= 0; r--) begin
            n_cmp++;
            if (rk_valid !== 1'b1 || rk_round !== 4'(r) || round_key !== exp_rk[r]) begin
                n_fail++;
                $display("FAIL ign_round: got valid=%b round=%0d key=%h, expected 1 %0d %h",
                         rk_valid, rk_round, round_key, r, exp_rk[r]);
            end
            @(posedge clk); #1;
        end
        rk_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        int lat;
        build_model(FIPS_KEY);
        rk_ready = 1'b1;
        do_start(FIPS_KEY);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
        end
        n_cmp++;
        if (rk_round !== 4'd5 || round_key !== exp_rk[5]) begin
            n_fail++;
            $display("FAIL arst_pre: got round=%0d key=%h, expected 5 %h", rk_round, round_key, exp_rk[5]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || round_key !== 128'h0 || rk_round !== 4'd0) begin
            n_fail++;
            $display("FAIL arst_immediate: got valid=%b busy=%b done=%b round=%0d key=%h, expected all zero",
                     rk_valid, busy, done, rk_round, round_key);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        n_cmp++;
        if (rk_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_no_emit: got valid=%b busy=%b, expected 0 0", rk_valid, busy);
        end
        build_model(ALT_KEY);
        do_start(ALT_KEY);
        wait_valid(lat);
        n_cmp++;
        if (lat !== 10) begin
            n_fail++;
            $display("FAIL arst_restart_latency: got %0d cycles, expected 10", lat);
        end
        for (int r = 10; r >= 0; r--) begin
            n_cmp++;
            if (rk_valid !== 1'b1 || rk_round !== 4'(r) || round_key !== exp_rk[r]) begin
                n_fail++;
                $display("FAIL arst_round: got valid=%b round=%0d key=%h, expected 1 %0d %h",
                         rk_valid, rk_round, round_key, r, exp_rk[r]);
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_done: got %b, expected 1", done);
        end
        rk_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [127:0] expv;
        build_model(128'h0);
        rk_ready = 1'b1;
        do_start(128'h0);
        wait_valid(lat);
        for (int r = 10; r >= 0; r--) begin
            expv = (r == 10) ? ZERO_R10 : exp_rk[r];
            n_cmp++;
            if (rk_valid !== 1'b1 || rk_round !== 4'(r) || round_key !== expv) begin
                n_fail++;
                $display("FAIL b2b_zero_round: got valid=%b round=%0d key=%h, expected 1 %0d %h",
                         rk_valid, rk_round, round_key, r, expv);
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done_cycle: got done=%b busy=%b, expected 1 0", done, busy);
        end
        build_model(ONES_KEY);
        do_start(ONES_KEY);
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_restart: got busy=%b done=%b, expected 1 0", busy, done);
        end
        wait_valid(lat);
        n_cmp++;
        if (lat !== 10) begin
            n_fail++;
            $display("FAIL b2b_latency: got %0d cycles, expected 10", lat);
        end
        for (int r = 10; r >= 0; r--) begin
            expv = (r == 0) ? ONES_KEY : exp_rk[r];
            n_cmp++;
            if (rk_valid !== 1'b1 || rk_round !== 4'(r) || round_key !== expv) begin
                n_fail++;
                $display("FAIL b2b_ones_round: got valid=%b round=%0d key=%h, expected 1 %0d %h",
                         rk_valid, rk_round, round_key, r, expv);
            end
            @(posedge clk); #1;
        end
        rk_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random_keys();
        int lat;
        logic [127:0] k;
        rk_ready = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            k = {$urandom(), $urandom(), $urandom(), $urandom()};
            build_model(k);
            do_start(k);
            wait_valid(lat);
            n_cmp++;
            if (lat !== 10) begin
                n_fail++;
                $display("FAIL rnd_latency: key=%h got %0d cycles, expected 10", k, lat);
            end
            for (int r = 10; r >= 0; r--) begin
                n_cmp++;
                if (rk_valid !== 1'b1 || rk_round !== 4'(r) || round_key !== exp_rk[r]) begin
                    n_fail++;
                    $display("FAIL rnd_round: key=%h got valid=%b round=%0d key=%h, expected 1 %0d %h",
                             k, rk_valid, rk_round, round_key, r, exp_rk[r]);
                end
                @(posedge clk); #1;
            end
        end
        rk_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_fips();
        test_random_ready();
        test_start_ignored();
        test_async_reset();
        test_back_to_back();
        test_random_keys();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog");
    end

endmodule
